spi_ram_master: RTL and testbench

//  Clocked SPI master driving the CoreLogic MCU slave port (mcu_nss/sck/mosi/miso).

---
 rtl/spi_ram_master.sv | 235 +++++++++++++++++++++++
 tb/tb_spi_ram_master.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_master.sv
// SPI mode-0 master that wraps a parallel RAM read/write command into a CoreLogic
// RAM-access transaction. Optional status read is enabled by SPI_RAM_MASTER_STATUS_EN.
module spi_ram_master #(
    parameter int          HALF_DIV      = 4,
    parameter logic [7:0]  ACCESS_OPCODE = 8'h01,
    parameter logic [7:0]  STATUS_OPCODE = 8'h02
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_len,
`ifdef SPI_RAM_MASTER_STATUS_EN
    input  logic        cmd_status,
`endif
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        mcu_nss,
    output logic        mcu_sck,
    output logic        mcu_mosi,
    input  logic        mcu_miso
);

    // Handshakes: cmd and wr transfer on a clk edge where valid && ready are both high;
    // rd_valid and done are single-cycle strobes with no backpressure.

    localparam int             CW        = $clog2(2 * HALF_DIV);
    localparam logic [CW-1:0]  HALF_LAST = CW'(HALF_DIV - 1);
    localparam logic [CW-1:0]  GAP_LAST  = CW'(2 * HALF_DIV - 1);

    localparam logic [2:0] B_OPC   = 3'd0;
    localparam logic [2:0] B_INSTR = 3'd1;
    localparam logic [2:0] B_AHI   = 3'd2;
    localparam logic [2:0] B_ALO   = 3'd3;
    localparam logic [2:0] B_DATA  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        TAIL  = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  hcnt;
    logic [2:0]     bit_cnt;
    logic [2:0]     byte_idx;
    logic [7:0]     data_cnt;
    logic [7:0]     tx_sr;
    logic [7:0]     rx_sr;
    logic [7:0]     rx_next;
    logic [15:0]    lat_addr;
    logic           lat_write;
    logic           lat_status;
    logic           status_req;

    logic           load_en;
    logic [7:0]     load_val;
    logic           wr_take;
    logic           half_tick;
    logic           is_data;
    logic           last_byte;
    logic           byte_end;
    logic           enter_data;

`ifdef SPI_RAM_MASTER_STATUS_EN
    assign status_req = cmd_status;
`else
    assign status_req = 1'b0;
`endif

    // CoreLogic shifts its opcode LSB first; the shifter always emits bit 7, so reverse it.
    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    assign rx_next   = lat_status ? {mcu_miso, rx_sr[7:1]} : {rx_sr[6:0], mcu_miso};
    assign cmd_ready = (state == IDLE);
    assign wr_ready  = wr_take & ~reset;

    always_comb begin
        state_n    = state;
        load_en    = 1'b0;
        load_val   = 8'h00;
        wr_take    = 1'b0;
        half_tick  = (hcnt == HALF_LAST);
        is_data    = (byte_idx == B_DATA);
        last_byte  = is_data && (data_cnt == 8'd0);
        byte_end   = (state == SHIFT) && mcu_sck && half_tick && (bit_cnt == 3'd7);
        enter_data = (byte_idx == B_ALO) || is_data || (lat_status && (byte_idx == B_OPC));
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_n  = SETUP;
                    load_en  = 1'b1;
                    load_val = status_req ? rev8(STATUS_OPCODE) : rev8(ACCESS_OPCODE);
                end
            end
            SETUP: begin
                if (half_tick) state_n = SHIFT;
            end
            SHIFT: begin
                if (byte_end) begin
                    if (last_byte) begin
                        state_n = TAIL;
                    end else if (!enter_data) begin
                        load_en = 1'b1;
                        case (byte_idx)
                            B_OPC:   load_val = lat_write ? 8'h02 : 8'h03;
                            B_INSTR: load_val = lat_addr[15:8];
                            B_AHI:   load_val = lat_addr[7:0];
                            default: load_val = 8'h00;
                        endcase
                    end else if (lat_write) begin
                        if (wr_valid) begin
                            wr_take  = 1'b1;
                            load_en  = 1'b1;
                            load_val = wr_data;
                        end else begin
                            state_n = HOLD;
                        end
                    end else begin
                        load_en = 1'b1;   // read data: MOSI idles at 0
                    end
                end
            end
            HOLD: begin
                if (wr_valid) begin
                    wr_take  = 1'b1;
                    load_en  = 1'b1;
                    load_val = wr_data;
                    state_n  = SHIFT;
                end
            end
            TAIL: begin
                if (half_tick) state_n = GAP;
            end
            GAP: begin
                if (hcnt == GAP_LAST) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hcnt       <= '0;
            bit_cnt    <= 3'd0;
            byte_idx   <= B_OPC;
            data_cnt   <= 8'd0;
            tx_sr      <= 8'h00;
            rx_sr      <= 8'h00;
            lat_addr   <= 16'h0000;
            lat_write  <= 1'b0;
            lat_status <= 1'b0;
            rd_data    <= 8'h00;
            rd_valid   <= 1'b0;
            done       <= 1'b0;
            mcu_nss    <= 1'b1;
            mcu_sck    <= 1'b0;
            mcu_mosi   <= 1'b0;
        end else begin
            state    <= state_n;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            hcnt     <= half_tick ? '0 : hcnt + CW'(1);
            case (state)
                IDLE: begin
                    hcnt     <= '0;
                    mcu_mosi <= 1'b0;
                    if (cmd_valid) begin
                        lat_addr   <= cmd_addr;
                        lat_write  <= cmd_write & ~status_req;
                        lat_status <= status_req;
                        data_cnt   <= status_req ? 8'd0 : cmd_len;
                        byte_idx   <= B_OPC;
                        mcu_nss    <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (half_tick) begin
                        if (!mcu_sck) begin
                            // Rising edge: MISO is captured as SCK goes high.
                            mcu_sck <= 1'b1;
                            rx_sr   <= rx_next;
                            if (is_data && !lat_write && (bit_cnt == 3'd7)) begin
                                rd_valid <= 1'b1;
                                rd_data  <= rx_next;
                            end
                        end else begin
                            mcu_sck <= 1'b0;
                            if (bit_cnt != 3'd7) begin
                                bit_cnt  <= bit_cnt + 3'd1;
                                tx_sr    <= {tx_sr[6:0], 1'b0};
                                mcu_mosi <= tx_sr[6];
                            end else begin
                                byte_idx <= enter_data ? B_DATA : byte_idx + 3'd1;
                                if (is_data) data_cnt <= data_cnt - 8'd1;
                                if (last_byte) mcu_mosi <= 1'b0;
                            end
                        end
                    end
                end
                HOLD: hcnt <= '0;
                TAIL: begin
                    if (half_tick) begin
                        mcu_nss <= 1'b1;
                        done    <= 1'b1;
                    end
                end
                GAP: hcnt <= hcnt + CW'(1);
                default: ;
            endcase
            // A new byte always starts with a full low half period.
            if (load_en) begin
                tx_sr    <= load_val;
                mcu_mosi <= load_val[7];
                bit_cnt  <= 3'd0;
                hcnt     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_master.sv
// Self-checking bench for spi_ram_master: vector table, hold/reset sequences and
// randomized transactions against a byte-level model of the SPI frame.
`timescale 1ns/1ps
module tb_spi_ram_master;

    localparam int HALF_DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = 16'h0000;
    logic [7:0]  cmd_len = 8'h00;
`ifdef SPI_RAM_MASTER_STATUS_EN
    logic        cmd_status = 1'b0;
`endif
    logic [7:0]  wr_data = 8'h00;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        done;
    logic        mcu_nss;
    logic        mcu_sck;
    logic        mcu_mosi;
    logic        mcu_miso = 1'b0;

    spi_ram_master #(
        .HALF_DIV      (HALF_DIV),
        .ACCESS_OPCODE (8'h01),
        .STATUS_OPCODE (8'h02)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
`ifdef SPI_RAM_MASTER_STATUS_EN
        .cmd_status (cmd_status),
`endif
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .done       (done),
        .mcu_nss    (mcu_nss),
        .mcu_sck    (mcu_sck),
        .mcu_mosi   (mcu_mosi),
        .mcu_miso   (mcu_miso)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_wire[$];
    logic [7:0]  got_wire[$];
    logic        mosi_bits[$];
    logic        miso_q[$];
    logic [7:0]  wr_q[$];
    int          rises = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0, acc_cnt = 0, rd_at_done = -1;
    logic        nss_at_done = 1'b0;
    bit          wr_took = 1'b0, wr_stall = 1'b0, sck_prev = 1'b0;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  len;
        logic [7:0]  first;
        logic [7:0]  step;
        logic [31:0] exp_hdr;
        int          exp_rises;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic logic [7:0] gw(input int i);
        return (got_wire.size() > i) ? got_wire[i] : 8'hxx;
    endfunction

    // Monitor: everything sampled on the falling clk edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mcu_sck && !sck_prev) begin
                    mosi_bits.push_back(mcu_mosi);
                    rises++;
                end
                if (wr_ready) begin
                    wr_cnt++;
                    if (wr_valid) wr_took = 1'b1;
                end
                if (rd_valid) begin
                    rd_cnt++;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rd_extra: got %0h, expected no read", rd_data);
                    end else begin
                        check("rd_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
                    end
                end
                if (cmd_valid && cmd_ready) acc_cnt++;
            end
            if (done) begin
                done_cnt++;
                rd_at_done  = rd_cnt;
                nss_at_done = mcu_nss;
            end
            sck_prev = mcu_sck;
        end
    end

    // Write-data driver: presents the head of wr_q, pops it after a consumed beat.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wr_took) begin
                wr_took = 1'b0;
                if (wr_q.size() > 0) void'(wr_q.pop_front());
            end
            wr_valid = (wr_q.size() > 0) && !wr_stall;
            wr_data  = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
        end
    end

    // Slave: first MISO bit on nSS fall, next bit after each SCK fall.
    initial begin
        forever begin
            @(negedge mcu_nss or negedge mcu_sck);
            mcu_miso = (miso_q.size() > 0) ? miso_q.pop_front() : 1'b0;
        end
    end

    // Reference model: the expected byte frame on MOSI (time-ordered bits, first bit in
    // bit 7), the MISO bit stream the slave returns, and the expected read bytes.
    task automatic model_txn(input bit wr, input bit st, input logic [15:0] addr,
                             input logic [7:0] len, input logic [7:0] data[$]);
        exp_wire.delete();
        exp_q.delete();
        miso_q.delete();
        wr_q.delete();
        if (st) begin
            exp_wire.push_back(rev8(8'h02));
            exp_wire.push_back(8'h00);
            repeat (8) miso_q.push_back(1'b0);
            for (int b = 0; b < 8; b++) miso_q.push_back(data[0][b]);
            exp_q.push_back(data[0]);
        end else begin
            exp_wire.push_back(rev8(8'h01));
            exp_wire.push_back(wr ? 8'h02 : 8'h03);
            exp_wire.push_back(addr[15:8]);
            exp_wire.push_back(addr[7:0]);
            repeat (32) miso_q.push_back(1'b0);
            for (int i = 0; i <= int'(len); i++) begin
                if (wr) begin
                    exp_wire.push_back(data[i]);
                    wr_q.push_back(data[i]);
                end else begin
                    exp_wire.push_back(8'h00);
                    exp_q.push_back(data[i]);
                    for (int b = 7; b >= 0; b--) miso_q.push_back(data[i][b]);
                end
            end
        end
    endtask

    task automatic start_cmd(input bit wr, input bit st, input logic [15:0] addr, input logic [7:0] len);
        int cyc;
        mosi_bits.delete();
        rises = 0; wr_cnt = 0; rd_cnt = 0; done_cnt = 0; acc_cnt = 0; rd_at_done = -1;
        wr_stall = 1'b0;
        @(posedge clk);
        #1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
`ifdef SPI_RAM_MASTER_STATUS_EN
        cmd_status = st;
`endif
        cmd_valid = 1'b1;
        cyc = 0;
        while (acc_cnt == 0 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        // Keep requesting while busy and scramble fields: neither may disturb the frame.
        repeat (20) begin
            @(posedge clk);
            #1;
            cmd_addr  = 16'($urandom);
            cmd_len   = 8'($urandom);
            cmd_write = 1'($urandom);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic run_txn(input bit wr, input bit st, input logic [15:0] addr,
                           input logic [7:0] len, input logic [7:0] data[$], input bit stall);
        int budget, cyc, r0, frz, exp_rd;
        bit stall_done;
        model_txn(wr, st, addr, len, data);
        start_cmd(wr, st, addr, len);
        budget = (int'(len) + 7) * 16 * HALF_DIV;
        cyc = 0;
        stall_done = 1'b0;
        while (done_cnt == 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (stall && !stall_done && wr_cnt == 1) begin
                wr_stall = 1'b1;
                repeat (70) @(negedge clk);
                r0 = rises;
                frz = 0;
                repeat (50) begin
                    @(negedge clk);
                    if (mcu_sck !== 1'b0 || mcu_nss !== 1'b0) frz++;
                end
                check("hold_frozen_cycles", frz, 0);
                check("hold_sck_rises", rises, r0);
                wr_stall = 1'b0;
                stall_done = 1'b1;
            end
        end
        repeat (4 * HALF_DIV + 4) @(negedge clk);
        got_wire.delete();
        for (int i = 0; i + 8 <= mosi_bits.size(); i += 8) begin
            logic [7:0] b;
            for (int k = 0; k < 8; k++) b[7-k] = mosi_bits[i+k];
            got_wire.push_back(b);
        end
        exp_rd = st ? 1 : (wr ? 0 : int'(len) + 1);
        check("done_count", done_cnt, 1);
        check("nss_at_done", {31'd0, nss_at_done}, 1);
        check("accepts", acc_cnt, 1);
        check("ready_idle", {31'd0, cmd_ready}, 1);
        check("sck_rises", rises, exp_wire.size() * 8);
        check("wr_ready_count", wr_cnt, (wr && !st) ? int'(len) + 1 : 0);
        check("rd_count", rd_cnt, exp_rd);
        if (exp_rd > 0) check("rd_before_done", rd_at_done, exp_rd);
        check("rd_left", exp_q.size(), 0);
        for (int i = 0; i < exp_wire.size(); i++)
            check($sformatf("mosi_byte%0d", i), {24'd0, gw(i)}, {24'd0, exp_wire[i]});
    endtask

    initial begin
        vec_t        tbl[5];
        logic [7:0]  d[$];
        bit          wr;
        logic [7:0]  len;

        tbl[0] = '{1'b1, 16'h1234, 8'd0,   8'hA5, 8'h00, 32'h80021234, 40};
        tbl[1] = '{1'b0, 16'h0010, 8'd3,   8'h11, 8'h11, 32'h80030010, 64};
        tbl[2] = '{1'b1, 16'hFFFF, 8'd7,   8'h00, 8'h01, 32'h8002FFFF, 96};
        tbl[3] = '{1'b0, 16'h8001, 8'd0,   8'h5A, 8'h00, 32'h80038001, 40};
        tbl[4] = '{1'b0, 16'h0000, 8'd255, 8'h00, 8'h01, 32'h80030000, 2080};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_nss",      {31'd0, mcu_nss},   1);
        check("rst_sck",      {31'd0, mcu_sck},   0);
        check("rst_mosi",     {31'd0, mcu_mosi},  0);
        check("rst_cmd_ready",{31'd0, cmd_ready}, 1);
        check("rst_wr_ready", {31'd0, wr_ready},  0);
        check("rst_rd_valid", {31'd0, rd_valid},  0);
        check("rst_done",     {31'd0, done},      0);
        check("rst_rd_data",  {24'd0, rd_data},   0);

        for (int v = 0; v < 5; v++) begin
            d.delete();
            for (int i = 0; i <= int'(tbl[v].len); i++) d.push_back(8'(tbl[v].first + tbl[v].step * i));
            run_txn(tbl[v].wr, 1'b0, tbl[v].addr, tbl[v].len, d, 1'b0);
            check($sformatf("tbl%0d_header", v), {gw(0), gw(1), gw(2), gw(3)}, tbl[v].exp_hdr);
            check($sformatf("tbl%0d_rises", v), rises, tbl[v].exp_rises);
        end

        d.delete();
        d.push_back(8'hC3);
        d.push_back(8'h3C);
        run_txn(1'b1, 1'b0, 16'h4242, 8'd1, d, 1'b1);

        d.delete();
        for (int i = 0; i < 6; i++) d.push_back(8'(8'h10 + i));
        model_txn(1'b1, 1'b0, 16'h0100, 8'd5, d);
        start_cmd(1'b1, 1'b0, 16'h0100, 8'd5);
        repeat (330) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_nss",   {31'd0, mcu_nss},   1);
        check("abort_ready", {31'd0, cmd_ready}, 1);
        check("abort_sck",   {31'd0, mcu_sck},   0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("abort_no_done",  done_cnt, 0);
        check("abort_nss_idle", {31'd0, mcu_nss},   1);
        check("abort_ready2",   {31'd0, cmd_ready}, 1);
        wr_q.delete();
        miso_q.delete();
        exp_q.delete();

        for (int r = 0; r < 6; r++) begin
            wr  = 1'($urandom_range(0, 1));
            len = 8'($urandom_range(0, 12));
            d.delete();
            for (int i = 0; i <= int'(len); i++) d.push_back(8'($urandom));
            run_txn(wr, 1'b0, 16'($urandom), len, d, 1'b0);
        end

`ifdef SPI_RAM_MASTER_STATUS_EN
        d.delete();
        d.push_back(8'h5C);
        run_txn(1'b1, 1'b1, 16'hBEEF, 8'd9, d, 1'b0);
        check("status_rises", rises, 16);
        check("status_rd_data", {24'd0, rd_data}, 32'h5C);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
